// File: rtl/spi_frame_pkg.sv
// Shared constants, field widths and FSM encoding for the SPI frame decoder.
// The frame header is {cmd, dest}; the MISO header is {status, chip_id}.
package spi_frame_pkg;

    localparam int CMD_W       = 4;
    localparam int ID_W        = 4;
    localparam int NONCE_W     = 32;
    localparam int CFG_W       = 32;
    localparam int CNT_FIELD_W = 8;

    localparam logic [CMD_W-1:0] CMD_CONFIG = 4'h0;
    localparam logic [CMD_W-1:0] CMD_JOB    = 4'h1;
    localparam logic [CMD_W-1:0] CMD_READ   = 4'h2;

    localparam logic [3:0]      STAT_IDLE  = 4'h5;
    localparam logic [3:0]      STAT_NONCE = 4'hA;
    localparam logic [ID_W-1:0] ID_BCAST   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_DECODE = 2'd2
    } fsm_state_t;

    function automatic logic id_match(input logic [ID_W-1:0] dest,
                                      input logic [ID_W-1:0] chip);
        return (dest == chip) || (dest == ID_BCAST);
    endfunction

endpackage

// File: rtl/spi_frame_decoder_if.sv
// Bus between the SPI shifter / hash core side and the frame decoder.
// job_valid/job_ready: a job transfers on any clk edge where both are high; job_valid
// is held with job_data stable (except replacement by a newer JOB frame) until that edge.
interface spi_frame_decoder_if #(
    parameter int FRAME_W = 360
);
    logic               cs_n;
    logic [FRAME_W-1:0] mosi_data;
    logic [FRAME_W-1:0] miso_data;
    logic [31:0]        cfg_word;
    logic               cfg_wr;
    logic [FRAME_W-9:0] job_data;
    logic               job_valid;
    logic               job_ready;
    logic               nonce_valid;
    logic [31:0]        nonce;
    logic               overrun;

    modport master (
        output cs_n, mosi_data, job_ready, nonce_valid, nonce,
        input  miso_data, cfg_word, cfg_wr, job_data, job_valid, overrun
    );

    modport slave (
        input  cs_n, mosi_data, job_ready, nonce_valid, nonce,
        output miso_data, cfg_word, cfg_wr, job_data, job_valid, overrun
    );
endinterface

// File: rtl/nonce_fifo.sv
// Small circular FIFO holding nonces until they are shown on MISO and read.
// A push while full is taken only if a pop happens in the same cycle.
module nonce_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // Pointers are PTR_W bits wide so they wrap modulo DEPTH on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spi_frame_decoder.sv
// System-clock side of the SPI slave: synchronises cs_n, decodes each finished MOSI
// frame into config writes or hash jobs, and builds the MISO frame from the nonce FIFO.
module spi_frame_decoder
    import spi_frame_pkg::*;
#(
    parameter int FRAME_W     = 360,
    parameter int NONCE_DEPTH = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ID_W-1:0]    chip_id,
    spi_frame_decoder_if.slave bus,
    output fsm_state_t         dbg_state
);
    localparam int PAYLOAD_W  = FRAME_W - CMD_W - ID_W;
    localparam int CNT_W      = $clog2(NONCE_DEPTH) + 1;
    localparam int MISO_PAD_W = PAYLOAD_W - NONCE_W - CNT_FIELD_W - 2;
    localparam int CLR_BIT    = PAYLOAD_W - CFG_W - 1;

    fsm_state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   cs_s, cs_s_q, armed_q, armed_d, end_p;

    logic [CFG_W-1:0]     cfg_word_q, cfg_word_d;
    logic                 cfg_wr_q, cfg_wr_d;
    logic [PAYLOAD_W-1:0] job_data_q, job_data_d;
    logic                 job_valid_q, job_valid_d;
    logic                 overrun_q, overrun_d;
    logic [3:0]           stat_q, stat_d;
    logic [PAYLOAD_W-1:0] body_q, body_d;
    logic                 shown_vld_q, shown_vld_d;

    logic [CMD_W-1:0]     f_cmd;
    logic [ID_W-1:0]      f_dest;
    logic [PAYLOAD_W-1:0] f_payload;
    logic                 accept, fifo_pop, fifo_drop;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [NONCE_W-1:0]   fifo_head;

    // Synchroniser resets low so a frame already in flight at reset is never decoded;
    // armed_q requires cs_s to be seen high before the FSM may leave IDLE.
    assign sync_d  = (sync_q << 1) | SYNC_STAGES'(bus.cs_n);
    assign cs_s    = sync_q[SYNC_STAGES-1];
    assign end_p   = cs_s && !cs_s_q;
    assign armed_d = armed_q || cs_s;

    assign f_cmd     = bus.mosi_data[FRAME_W-1 -: CMD_W];
    assign f_dest    = bus.mosi_data[FRAME_W-CMD_W-1 -: ID_W];
    assign f_payload = bus.mosi_data[PAYLOAD_W-1:0];
    assign accept    = (state_q == ST_DECODE) && id_match(f_dest, chip_id);
    assign fifo_pop  = accept && shown_vld_q;
    assign fifo_drop = bus.nonce_valid && fifo_full && !fifo_pop;

    nonce_fifo #(
        .DEPTH (NONCE_DEPTH),
        .WIDTH (NONCE_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.nonce_valid),
        .wdata   (bus.nonce),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (armed_q && !cs_s) state_d = ST_FRAME;
            ST_FRAME:  if (end_p) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_word_d  = cfg_word_q;
        cfg_wr_d    = 1'b0;
        job_data_d  = job_data_q;
        job_valid_d = job_valid_q && !bus.job_ready;
        overrun_d   = overrun_q;
        stat_d      = stat_q;
        body_d      = body_q;
        shown_vld_d = shown_vld_q;

        if (accept) begin
            case (f_cmd)
                CMD_CONFIG: begin
                    cfg_word_d = f_payload[PAYLOAD_W-1 -: CFG_W];
                    cfg_wr_d   = 1'b1;
                    if (f_payload[CLR_BIT]) overrun_d = 1'b0;
                end
                CMD_JOB: begin
                    job_data_d  = f_payload;
                    job_valid_d = 1'b1;
                    if (job_valid_q && !bus.job_ready) overrun_d = 1'b1;
                end
                CMD_READ: ;
                default: ;
            endcase
        end
        if (fifo_drop) overrun_d = 1'b1;

        // MISO is only rebuilt while cs is high so the shifter sees a stable frame.
        if (state_q == ST_IDLE && cs_s) begin
            stat_d      = fifo_empty ? STAT_IDLE : STAT_NONCE;
            body_d      = {(fifo_empty ? '0 : fifo_head), CNT_FIELD_W'(fifo_count),
                           job_valid_q, overrun_q, {MISO_PAD_W{1'b0}}};
            shown_vld_d = !fifo_empty;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            cs_s_q      <= 1'b0;
            armed_q     <= 1'b0;
            cfg_word_q  <= '0;
            cfg_wr_q    <= 1'b0;
            job_data_q  <= '0;
            job_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            stat_q      <= STAT_IDLE;
            body_q      <= '0;
            shown_vld_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cs_s_q      <= cs_s;
            armed_q     <= armed_d;
            cfg_word_q  <= cfg_word_d;
            cfg_wr_q    <= cfg_wr_d;
            job_data_q  <= job_data_d;
            job_valid_q <= job_valid_d;
            overrun_q   <= overrun_d;
            stat_q      <= stat_d;
            body_q      <= body_d;
            shown_vld_q <= shown_vld_d;
        end
    end

    assign bus.miso_data = {stat_q, chip_id, body_q};
    assign bus.cfg_word  = cfg_word_q;
    assign bus.cfg_wr    = cfg_wr_q;
    assign bus.job_data  = job_data_q;
    assign bus.job_valid = job_valid_q;
    assign bus.overrun   = overrun_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Self-checking bench for spi_frame_decoder: directed corner sequences, a decode
// vector table, and randomized frames checked against a queue-based model.
module tb_spi_frame_decoder;
    import spi_frame_pkg::*;

    localparam logic [3:0] CHIP = 4'h7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] chip_id;
    fsm_state_t dbg_state;

    spi_frame_decoder_if #(.FRAME_W(360)) bus ();

    spi_frame_decoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chip_id   (chip_id),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard / model ----------------
    int tests = 0;
    int fails = 0;

    logic [31:0]  m_q[$];
    logic         m_jv, m_ov;
    logic [31:0]  m_cfg;
    logic [351:0] m_job;

    typedef struct {
        logic [3:0]  cmd;
        logic [3:0]  dest;
        logic [31:0] word;
        logic        exp_wr;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [359:0] act, input logic [359:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [359:0] mk_frame(input logic [3:0] cmd, input logic [3:0] dest,
                                              input logic [351:0] payload);
        return {cmd, dest, payload};
    endfunction

    function automatic logic [351:0] cfg_payload(input logic [31:0] w, input logic clr);
        return {w, clr, 319'b0};
    endfunction

    function automatic logic [351:0] rand_payload();
        logic [351:0] p;
        for (int i = 0; i < 11; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [359:0] exp_miso();
        logic [359:0] e;
        e = '0;
        e[359:356] = (m_q.size() != 0) ? 4'hA : 4'h5;
        e[355:352] = CHIP;
        if (m_q.size() != 0) e[351:320] = m_q[0];
        e[319:312] = 8'(m_q.size());
        e[311] = m_jv;
        e[310] = m_ov;
        return e;
    endfunction

    task automatic model_push(input logic [31:0] v);
        if (m_q.size() < 4) m_q.push_back(v);
        else m_ov = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_nonce(input logic [31:0] v);
        @(posedge clk);
        #1 bus.nonce_valid = 1'b1;
        bus.nonce = v;
        @(posedge clk);
        #1 bus.nonce_valid = 1'b0;
    endtask

    // Full frame; returns at the negedge after the decode result is registered.
    task automatic run_frame(input logic [359:0] f, input bit rdy_pulse,
                             input bit push_pulse, input logic [31:0] pv);
        @(posedge clk);
        #1 bus.mosi_data = f;
        bus.cs_n = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (rdy_pulse) bus.job_ready = 1'b1;
        if (push_pulse) begin
            bus.nonce_valid = 1'b1;
            bus.nonce = pv;
        end
        @(posedge clk);
        #1;
        if (rdy_pulse) bus.job_ready = 1'b0;
        bus.nonce_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_wait();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [359:0] f;
        logic [351:0] pa5, p1, p2, p3;
        bit held;

        vecs[0] = '{4'h0, 4'h3, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{4'h0, 4'hF, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{4'h0, 4'h7, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        vecs[3] = '{4'h5, 4'h7, 32'h11112222, 1'b0, 32'hCAFEF00D};
        vecs[4] = '{4'h2, 4'hF, 32'h33334444, 1'b0, 32'hCAFEF00D};
        vecs[5] = '{4'h0, 4'h8, 32'h55556666, 1'b0, 32'hCAFEF00D};
        vecs[6] = '{4'h0, 4'h7, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};

        reset_n = 1'b0;
        chip_id = CHIP;
        bus.cs_n = 1'b1;
        bus.mosi_data = '0;
        bus.job_ready = 1'b0;
        bus.nonce_valid = 1'b0;
        bus.nonce = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        // 1: reset / idle frame
        check("t1_miso_hdr", bus.miso_data[359:352], {4'h5, CHIP});
        check("t1_miso", bus.miso_data, {4'h5, CHIP, 352'b0});
        check("t1_cfg_word", bus.cfg_word, 0);
        check("t1_cfg_wr", bus.cfg_wr, 0);
        check("t1_job_valid", bus.job_valid, 0);
        check("t1_job_data", bus.job_data, 0);
        check("t1_overrun", bus.overrun, 0);

        // 2: JOB latency, hold and handshake
        pa5 = {11{32'hA5A5A5A5}};
        @(posedge clk);
        #1 bus.mosi_data = mk_frame(4'h1, CHIP, pa5);
        bus.cs_n = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t2_jv_edge3", bus.job_valid, 0);
        check("t2_state_decode", dbg_state, ST_DECODE);
        @(posedge clk);
        @(negedge clk);
        check("t2_jv_edge4", bus.job_valid, 1);
        check("t2_job_data", bus.job_data, pa5);
        held = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.job_valid !== 1'b1) held = 1'b0;
        end
        check("t2_jv_held", held, 1);
        @(posedge clk);
        #1 bus.job_ready = 1'b1;
        @(negedge clk);
        check("t2_jv_before_xfer", bus.job_valid, 1);
        @(posedge clk);
        #1 bus.job_ready = 1'b0;
        @(negedge clk);
        check("t2_jv_after_xfer", bus.job_valid, 0);
        check("t2_overrun", bus.overrun, 0);

        // 3: decode vector table
        @(posedge clk);
        #1 bus.job_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_frame(mk_frame(vecs[i].cmd, vecs[i].dest, cfg_payload(vecs[i].word, 1'b0)), 0, 0, 0);
            check($sformatf("t3_vec%0d_cfg_wr", i), bus.cfg_wr, vecs[i].exp_wr);
            check($sformatf("t3_vec%0d_cfg_word", i), bus.cfg_word, vecs[i].exp_word);
            check($sformatf("t3_vec%0d_job_valid", i), bus.job_valid, 0);
            @(negedge clk);
            check($sformatf("t3_vec%0d_cfg_wr_end", i), bus.cfg_wr, 0);
        end

        // 4: nonce pushed during FRAME stays hidden until cs high, then READ pops it
        @(posedge clk);
        #1 bus.mosi_data = mk_frame(4'h2, CHIP, '0);
        bus.cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.nonce_valid = 1'b1;
        bus.nonce = 32'h12345678;
        @(posedge clk);
        #1 bus.nonce_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t4_frozen_stat", bus.miso_data[359:356], 4'h5);
        check("t4_frozen_nonce", bus.miso_data[351:320], 0);
        @(posedge clk);
        #1 bus.cs_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t4_stat_nonce", bus.miso_data[359:356], 4'hA);
        check("t4_nonce", bus.miso_data[351:320], 32'h12345678);
        check("t4_count1", bus.miso_data[319:312], 1);
        run_frame(mk_frame(4'h2, CHIP, '0), 0, 0, 0);
        idle_wait();
        check("t4_stat_after_pop", bus.miso_data[359:356], 4'h5);
        check("t4_count0", bus.miso_data[319:312], 0);

        // 5: FIFO overflow, simultaneous push/pop at full, overrun clear
        for (int k = 1; k <= 6; k++) push_nonce(32'h10000000 + k);
        idle_wait();
        check("t5_count4", bus.miso_data[319:312], 4);
        check("t5_head_n1", bus.miso_data[351:320], 32'h10000001);
        check("t5_overrun", bus.overrun, 1);
        check("t5_miso_ov", bus.miso_data[310], 1);
        run_frame(mk_frame(4'h2, CHIP, '0), 0, 1, 32'h10000007);
        idle_wait();
        check("t5_pushpop_count", bus.miso_data[319:312], 4);
        check("t5_pushpop_head", bus.miso_data[351:320], 32'h10000002);
        run_frame(mk_frame(4'h0, CHIP, cfg_payload(32'h0, 1'b1)), 0, 0, 0);
        check("t5_ov_cleared", bus.overrun, 0);
        check("t5_clr_cfg_wr", bus.cfg_wr, 1);
        idle_wait();
        check("t5_count3", bus.miso_data[319:312], 3);
        check("t5_head_n3", bus.miso_data[351:320], 32'h10000003);

        // 6: job replacement rules, then reset mid-frame
        p1 = {11{32'h11111111}};
        p2 = {11{32'h22222222}};
        p3 = {11{32'h33333333}};
        @(posedge clk);
        #1 bus.job_ready = 1'b0;
        run_frame(mk_frame(4'h1, CHIP, p1), 0, 0, 0);
        check("t6_j1_valid", bus.job_valid, 1);
        check("t6_j1_data", bus.job_data, p1);
        run_frame(mk_frame(4'h1, 4'hF, p2), 1, 0, 0);
        check("t6_same_cycle_valid", bus.job_valid, 1);
        check("t6_same_cycle_data", bus.job_data, p2);
        check("t6_same_cycle_ov", bus.overrun, 0);
        run_frame(mk_frame(4'h1, CHIP, p3), 0, 0, 0);
        check("t6_replace_data", bus.job_data, p3);
        check("t6_replace_valid", bus.job_valid, 1);
        check("t6_replace_ov", bus.overrun, 1);

        f = mk_frame(4'h1, CHIP, pa5);
        @(posedge clk);
        #1 bus.mosi_data = f;
        bus.cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_jv", bus.job_valid, 0);
        check("t6_rst_job_data", bus.job_data, 0);
        check("t6_rst_ov", bus.overrun, 0);
        check("t6_rst_cfg_word", bus.cfg_word, 0);
        check("t6_rst_cfg_wr", bus.cfg_wr, 0);
        check("t6_rst_miso", bus.miso_data, {4'h5, CHIP, 352'b0});
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.cs_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t6_no_decode_jv", bus.job_valid, 0);
        check("t6_no_decode_data", bus.job_data, 0);
        check("t6_state_idle", dbg_state, ST_IDLE);

        // random frames against the model
        m_q.delete();
        m_jv = 1'b0;
        m_ov = 1'b0;
        m_cfg = '0;
        m_job = '0;
        for (int it = 0; it < 40; it++) begin
            logic [3:0]   cmd, dest;
            logic [351:0] pl;
            logic [31:0]  v;
            bit           rdy, shown, acc;
            logic         exp_wr;
            int           np, r;

            rdy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 bus.job_ready = rdy;
            if (rdy) m_jv = 1'b0;
            np = $urandom_range(0, 3);
            for (int k = 0; k < np; k++) begin
                v = $urandom;
                push_nonce(v);
                model_push(v);
            end
            idle_wait();
            check($sformatf("rnd%0d_miso", it), bus.miso_data, exp_miso());
            shown = (m_q.size() != 0);

            r = $urandom_range(0, 4);
            cmd = (r < 3) ? 4'(r) : 4'($urandom_range(3, 15));
            r = $urandom_range(0, 2);
            dest = (r == 0) ? CHIP : (r == 1) ? 4'hF : 4'($urandom_range(0, 15));
            pl = rand_payload();
            run_frame(mk_frame(cmd, dest, pl), 0, 0, 0);

            acc = (dest == CHIP) || (dest == 4'hF);
            exp_wr = 1'b0;
            if (acc) begin
                if (shown) void'(m_q.pop_front());
                if (cmd == 4'h0) begin
                    m_cfg = pl[351:320];
                    exp_wr = 1'b1;
                    if (pl[319]) m_ov = 1'b0;
                end else if (cmd == 4'h1) begin
                    if (m_jv && !rdy) m_ov = 1'b1;
                    m_job = pl;
                    m_jv = 1'b1;
                end
            end
            check($sformatf("rnd%0d_cfg_wr", it), bus.cfg_wr, exp_wr);
            check($sformatf("rnd%0d_cfg_word", it), bus.cfg_word, m_cfg);
            check($sformatf("rnd%0d_job_valid", it), bus.job_valid, m_jv);
            check($sformatf("rnd%0d_job_data", it), bus.job_data, m_job);
            check($sformatf("rnd%0d_overrun", it), bus.overrun, m_ov);
            if (rdy) m_jv = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
